md_issue_ctrl: RTL and testbench
================================

// Module: md_issue_ctrl
// PURPOSE
//  Issue/hazard controller directly upstream of the multiply/divide unit. Decodes the E-stage
//  instruction and drives the unit's start, operands and opcode. Tracks a shadow busy window and
//  produces the D-stage stall for any mult/div/mfhi/mflo/mthi/mtlo behind an in-flight operation.
//  Cross-checks the unit's busy against its own shadow (sticky error) and counts stall cycles.
// PARAMETERS
//  MUL_LAT  5   cycles busy after a mult/multu start edge (must match the unit)
//  DIV_LAT  10  cycles busy after a div/divu start edge (must match the unit)
//  CNT_W    4   width of the latency down-counter (holds max(MUL_LAT,DIV_LAT))
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   synchronous, active-high
//  ir_d         in   32  instruction in D stage
//  ir_e         in   32  instruction in E stage
//  valid_e      in   1   E-stage slot holds a real instruction (0 = bubble)
//  flush_e      in   1   E-stage instruction is being killed this cycle
//  rs_e         in   32  forwarded rs value in E
//  rt_e         in   32  forwarded rt value in E
//  md_busy      in   1   busy from the mul/div unit
//  md_start     out  1   one-cycle start pulse to the unit
//  md_a, md_b   out  32  operands to the unit (rs_e, rt_e)
//  md_op        out  2   0 mult, 1 multu, 2 div, 3 divu (valid while md_start=1)
//  stall_d      out  1   freeze F/D, insert bubble into E
//  busy_err     out  1   sticky: md_busy disagreed with the shadow busy
//  stall_cnt    out  32  count of cycles with stall_d=1
// BEHAVIOUR
//  - Decode only when opcode ir[31:26]=0. Funct: 011000 mult, 011001 multu, 011010 div, 011011 divu
//    (class START); 010000 mfhi, 010010 mflo (class MF); 010001 mthi, 010011 mtlo (class MT).
//    Class MD = START|MF|MT. Any other encoding is class NONE.
//  - go_e = valid_e & ~flush_e & START(ir_e). md_start = go_e & (state==IDLE); combinational.
//  - md_a=rs_e, md_b=rt_e, md_op=funct[1:0]; combinational, don't-care when md_start=0.
//  - FSM: IDLE, BUSY. IDLE->BUSY on md_start, cnt <= MUL_LAT (op 0/1) or DIV_LAT (op 2/3).
//    BUSY: cnt <= cnt-1 each edge; when cnt==1 -> IDLE, cnt <= 0. Shadow busy = (state==BUSY),
//    high for exactly MUL_LAT/DIV_LAT cycles after the start edge.
//  - stall_d = MD(ir_d) & (state==BUSY | go_e); combinational. Non-MD instructions never stall.
//    A D-stage MD instruction leaves stall in the cycle in which the FSM returns to IDLE
//    (i.e. the cycle after cnt==1), giving issue-to-issue spacing LAT+1 with back-to-back ops.
//  - go_e while BUSY cannot happen through stall_d; if it does (e.g. after reset), no start
//    is issued and busy_err sets.
//  - busy_err: set on any edge where state!=IDLE and md_busy!=1, or state==IDLE and md_busy==1,
//    excluding the start edge itself; cleared only by reset.
//  - stall_cnt: +1 per edge with stall_d=1; wraps 0xFFFFFFFF->0.
//  - flush_e and go_e in the same cycle: no start, FSM unchanged, stall_d computed without go_e.
//  - Reset (any cycle, incl. mid-operation): state=IDLE, cnt=0, busy_err=0, stall_cnt=0;
//    md_start=0 and stall_d=0 during the reset cycle regardless of inputs.
// STRUCTURE
//  - Shared package md_pkg: funct constants, md_op encoding, class enum (NONE/START/MF/MT),
//    default MUL_LAT/DIV_LAT.
//  - Sub-module md_decode (combinational classifier, ir -> class, md_op), instantiated for
//    ir_d and ir_e. FSM, counter, error and statistic logic stay in md_issue_ctrl.
// TESTING
//  - mult in E (rs=7,rt=6), valid, IDLE -> md_start=1, md_op=0, md_a=7, md_b=6; shadow busy 5 cycles.
//  - div in E, mflo in D -> stall_d=1 for 11 cycles (go cycle + 10 BUSY), then 0; stall_cnt=11.
//  - mult then add in D -> stall_d=0 throughout; stall_cnt unchanged.
//  - mult in E with flush_e=1 -> md_start=0, state stays IDLE, no stall for mthi in D.
//  - reset at cycle 3 of a divu -> state IDLE, stall_d=0, stall_cnt=0 next cycle; new mult issues.
//  - md_busy forced low at cycle 2 of a mult -> busy_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue controller: funct codes,
// unit opcode encoding, instruction classes and default latencies.
package md_pkg;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;
  localparam int unsigned CNT_W_DEF   = 4;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_START = 2'd1,
    CLS_MF    = 2'd2,
    CLS_MT    = 2'd3
  } md_class_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline-side bundle of the mul/div issue controller: D/E-stage inputs,
// unit handshake and hazard/status outputs.
interface md_issue_ctrl_if;

  logic [31:0] ir_d;
  logic [31:0] ir_e;
  logic        valid_e;
  logic        flush_e;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        md_busy;
  logic        md_start;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [1:0]  md_op;
  logic        stall_d;
  logic        busy_err;
  logic [31:0] stall_cnt;

  modport master (
    output ir_d, ir_e, valid_e, flush_e, rs_e, rt_e, md_busy,
    input  md_start, md_a, md_b, md_op, stall_d, busy_err, stall_cnt
  );

  modport slave (
    input  ir_d, ir_e, valid_e, flush_e, rs_e, rt_e, md_busy,
    output md_start, md_a, md_b, md_op, stall_d, busy_err, stall_cnt
  );

endinterface

// File: rtl/md_decode.sv
// Combinational classifier: maps an instruction's opcode/funct fields to its
// mul/div class and the unit opcode.
module md_decode
  import md_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output md_class_e  cls,
  output md_op_e     op
);

  always_comb begin
    cls = CLS_NONE;
    op  = md_op_e'(funct[1:0]);
    if (opcode == OPC_SPECIAL) begin
      case (funct)
        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: cls = CLS_START;
        FUNCT_MFHI, FUNCT_MFLO:                         cls = CLS_MF;
        FUNCT_MTHI, FUNCT_MTLO:                         cls = CLS_MT;
        default:                                        cls = CLS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/hazard controller in front of the multiply/divide unit: starts operations,
// tracks a shadow busy window, stalls dependent D-stage ops, checks the unit's busy.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  md_issue_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_class_e        cls_d;
  md_class_e        cls_e;
  md_op_e           op_e;
  md_op_e           unused_op_d;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_err_q, busy_err_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic             go_e;
  logic             start;
  logic             stall;
  logic             shadow_busy;

  md_decode u_dec_d (
    .opcode (bus.ir_d[31:26]),
    .funct  (bus.ir_d[5:0]),
    .cls    (cls_d),
    .op     (unused_op_d)
  );

  md_decode u_dec_e (
    .opcode (bus.ir_e[31:26]),
    .funct  (bus.ir_e[5:0]),
    .cls    (cls_e),
    .op     (op_e)
  );

  // Issue, hazard, shadow-busy countdown, cross-check and stall statistics.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_err_d  = busy_err_q;
    stall_cnt_d = stall_cnt_q;

    shadow_busy = (state_q == ST_BUSY);
    go_e        = bus.valid_e & ~bus.flush_e & (cls_e == CLS_START);
    start       = ~reset & go_e & ~shadow_busy;
    stall       = ~reset & (cls_d != CLS_NONE) & (shadow_busy | go_e);

    if (!shadow_busy) begin
      if (start) begin
        state_d = ST_BUSY;
        cnt_d   = ((op_e == OP_DIV) || (op_e == OP_DIVU)) ? DIV_CNT : MUL_CNT;
      end
    end else if (cnt_q == CNT_ONE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end

    // The unit only raises busy after the start edge, so that edge is not checked.
    if (!start && (shadow_busy != bus.md_busy)) busy_err_d = 1'b1;
    if (go_e && shadow_busy)                   busy_err_d = 1'b1;

    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_err_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_err_q  <= busy_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.md_start  = start;
  assign bus.md_a      = bus.rs_e;
  assign bus.md_b      = bus.rt_e;
  assign bus.md_op     = 2'(op_e);
  assign bus.stall_d   = stall;
  assign bus.busy_err  = busy_err_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed and randomized checks of md_issue_ctrl against a remaining-busy-cycles
// reference model.
module tb_md_issue_ctrl;

  logic clk;
  logic reset;

  md_issue_ctrl_if bus ();

  md_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passes = 0;
  int unsigned total  = 0;

  // Reference state: cycles of unit occupancy left, sticky error, stall count.
  int unsigned m_rem = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  logic obs_start;
  logic obs_stall;

  logic [5:0] fn_tbl [10] = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12, 6'h11, 6'h13, 6'h20, 6'h2a};

  localparam logic [5:0] F_MULT = 6'h18, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12, F_MTHI = 6'h11, F_ADD = 6'h20;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // 0 none, 1 start, 2 move-from, 3 move-to
  function automatic int cls_of(input logic [31:0] ir);
    if (ir[31:26] != 6'd0) return 0;
    case (ir[5:0])
      6'h18, 6'h19, 6'h1a, 6'h1b: return 1;
      6'h10, 6'h12:               return 2;
      6'h11, 6'h13:               return 3;
      default:                    return 0;
    endcase
  endfunction

  function automatic int unsigned lat_of(input logic [31:0] ir);
    return (ir[5:0] == 6'h18 || ir[5:0] == 6'h19) ? 5 : 10;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] fn);
    logic [31:0] ir;
    ir = {6'd0, 20'($urandom), fn};
    return ir;
  endfunction

  function automatic logic [31:0] rnd_ir();
    logic [31:0] ir;
    ir = mk(fn_tbl[$urandom_range(0, 9)]);
    if ($urandom_range(0, 7) == 0) ir[31:26] = 6'($urandom_range(1, 63));
    return ir;
  endfunction

  task automatic drv(input logic [31:0] d, input logic [31:0] e, input bit v, input bit f,
                     input logic [31:0] a, input logic [31:0] b);
    bus.ir_d    = d;
    bus.ir_e    = e;
    bus.valid_e = v;
    bus.flush_e = f;
    bus.rs_e    = a;
    bus.rt_e    = b;
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registers.
  task automatic tick(input bit flip = 1'b0);
    bit go, es, est;
    bus.md_busy = (m_rem != 0) ^ flip;
    #2;
    go  = bus.valid_e && !bus.flush_e && (cls_of(bus.ir_e) == 1);
    es  = !reset && go && (m_rem == 0);
    est = !reset && (cls_of(bus.ir_d) != 0) && ((m_rem != 0) || go);
    chk("md_start", 32'(bus.md_start), 32'(es));
    chk("stall_d", 32'(bus.stall_d), 32'(est));
    if (es) begin
      chk("md_op", 32'(bus.md_op), 32'(bus.ir_e[1:0]));
      chk("md_a", bus.md_a, bus.rs_e);
      chk("md_b", bus.md_b, bus.rt_e);
    end
    obs_start = bus.md_start;
    obs_stall = bus.stall_d;
    @(posedge clk);
    if (reset) begin
      m_rem = 0;
      m_err = 1'b0;
      m_cnt = 32'd0;
    end else begin
      if (est) m_cnt = m_cnt + 32'd1;
      if (!es && ((m_rem != 0) != bus.md_busy)) m_err = 1'b1;
      if (go && m_rem != 0) m_err = 1'b1;
      if (es) m_rem = lat_of(bus.ir_e);
      else if (m_rem != 0) m_rem--;
    end
    #1;
    chk("busy_err", 32'(bus.busy_err), 32'(m_err));
    chk("stall_cnt", bus.stall_cnt, m_cnt);
  endtask

  logic [31:0] base;

  initial begin
    reset = 1'b1;
    drv(mk(F_MFHI), mk(F_MULT), 1'b1, 1'b0, 32'd1, 32'd2);
    tick();
    chk("rst_start", 32'(obs_start), 32'd0);
    chk("rst_stall", 32'(obs_stall), 32'd0);
    tick();
    chk("rst_err", 32'(bus.busy_err), 32'd0);
    chk("rst_cnt", bus.stall_cnt, 32'd0);
    reset = 1'b0;

    // mult issue, 5-cycle shadow busy seen through an mfhi stall
    drv(mk(F_MFHI), mk(F_MULT), 1'b1, 1'b0, 32'd7, 32'd6);
    tick();
    chk("mult_start", 32'(obs_start), 32'd1);
    drv(mk(F_MFHI), 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mult_busy_stall", 32'(obs_stall), 32'd1);
    end
    tick();
    chk("mult_done_stall", 32'(obs_stall), 32'd0);

    // div with mflo behind: 11 stall cycles
    base = m_cnt;
    drv(mk(F_MFLO), mk(F_DIV), 1'b1, 1'b0, 32'd100, 32'd7);
    tick();
    chk("div_go_stall", 32'(obs_stall), 32'd1);
    drv(mk(F_MFLO), 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("div_last_stall", 32'(obs_stall), 32'd1);
    tick();
    chk("div_done_stall", 32'(obs_stall), 32'd0);
    chk("div_stall_cnt", bus.stall_cnt, base + 32'd11);

    // mult then add: never stalls
    base = m_cnt;
    drv(mk(F_ADD), mk(F_MULT), 1'b1, 1'b0, 32'd3, 32'd4);
    tick();
    drv(mk(F_ADD), 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("add_no_stall", 32'(obs_stall), 32'd0);
    end
    chk("add_cnt_same", bus.stall_cnt, base);

    // flushed mult: no start, no stall for mthi
    drv(mk(F_MTHI), mk(F_MULT), 1'b1, 1'b1, 32'd9, 32'd9);
    tick();
    chk("flush_start", 32'(obs_start), 32'd0);
    chk("flush_stall", 32'(obs_stall), 32'd0);
    drv(mk(F_MTHI), 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("flush_idle", 32'(obs_stall), 32'd0);

    // reset in cycle 3 of a divu, then a fresh mult issues
    drv(mk(F_MFLO), mk(F_DIVU), 1'b1, 1'b0, 32'd50, 32'd5);
    tick();
    drv(mk(F_MFLO), 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_stall", 32'(obs_stall), 32'd0);
    reset = 1'b0;
    chk("midrst_cnt", bus.stall_cnt, 32'd0);
    drv(mk(F_MFLO), mk(F_MULT), 1'b1, 1'b0, 32'd11, 32'd12);
    tick();
    chk("midrst_restart", 32'(obs_start), 32'd1);
    drv(mk(F_ADD), 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) tick();

    // unit busy drops early: sticky error until reset
    drv(mk(F_ADD), mk(F_MULT), 1'b1, 1'b0, 32'd1, 32'd1);
    tick();
    drv(mk(F_ADD), 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("err_clean", 32'(bus.busy_err), 32'd0);
    tick(1'b1);
    chk("err_set", 32'(bus.busy_err), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("err_sticky", 32'(bus.busy_err), 32'd1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("err_cleared", 32'(bus.busy_err), 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drv(rnd_ir(), rnd_ir(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
          $urandom, $urandom);
      reset = ($urandom_range(0, 149) == 0);
      tick(1'($urandom_range(0, 299) == 0));
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
